// File: rtl/team_06_adc_sample_ctrl.sv
// ADC serial sample controller: CONV/GAP sequencer feeding a sample buffer.
// Define ADC_CTRL_FIFO_EN for a FIFO_DEPTH-entry FIFO; default is one register.
module team_06_adc_sample_ctrl #(
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       spiclk,
  input  logic       rst,
  input  logic       en,
  input  logic       adc_serial_in,
  output logic       adc_cs_n,
  output logic [7:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy,
  output logic       overflow,
  input  logic       clr_ovf
);

`ifdef ADC_CTRL_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
  localparam int PW = $clog2(2 * DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] IMASK = PW'(DEPTH - 1);
  localparam logic [PW-1:0] FULLV = PW'(DEPTH);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] gap_cnt, gap_cnt_d;
  logic [7:0] shift, shift_d;
  logic [7:0] word;
  logic       push;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, occ;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          empty, full, pop, push_ok, ovf_evt;

  // Sequencer state, counters and shift register.
  always_ff @(posedge spiclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      shift   <= shift_d;
    end
  end

  // Next state: 8 shift cycles, then GAP_CYCLES of chip-select high.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    shift_d   = shift;
    push      = 1'b0;
    word      = {shift[6:0], adc_serial_in};
    unique case (state)
      IDLE: begin
        if (en) begin
          state_d   = CONV;
          bit_cnt_d = '0;
        end
      end
      CONV: begin
        shift_d   = word;
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          push      = 1'b1;
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_d   = en ? CONV : IDLE;
          bit_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc_cs_n = (state != CONV);
  assign busy     = (state != IDLE);

  // Pointers carry one extra bit so full and empty differ.
  assign occ     = wr_ptr - rd_ptr;
  assign empty   = (occ == '0);
  assign full    = (occ == FULLV);
  assign wr_idx  = IW'(wr_ptr & IMASK);
  assign rd_idx  = IW'(rd_ptr & IMASK);
  assign pop     = !empty && sample_ready;
  assign push_ok = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  assign sample_valid = !empty;
  assign sample_data  = mem[rd_idx];

  // Buffer storage, pointers and sticky overflow.
  always_ff @(posedge spiclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) begin
        mem[wr_idx] <= word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (ovf_evt) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_team_06_adc_sample_ctrl.sv
// Bench for team_06_adc_sample_ctrl: random words vs a queue-based model.
// Model depth follows ADC_CTRL_FIFO_EN.
module tb_team_06_adc_sample_ctrl;

  localparam int G = 8;
`ifdef ADC_CTRL_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic       spiclk;
  logic       rst;
  logic       en;
  logic       adc_serial_in;
  logic       adc_cs_n;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       busy;
  logic       overflow;
  logic       clr_ovf;

  team_06_adc_sample_ctrl dut (
    .spiclk        (spiclk),
    .rst           (rst),
    .en            (en),
    .adc_serial_in (adc_serial_in),
    .adc_cs_n      (adc_cs_n),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .overflow      (overflow),
    .clr_ovf       (clr_ovf)
  );

  initial spiclk = 1'b0;
  always #5 spiclk = ~spiclk;

  // Model: ph = -1 idle, 0..7 bit slot, 8..7+G gap cycle.
  int         ph;
  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] txw;
  logic [7:0] txq[$];
  int         started;
  int         pass_cnt;
  int         tot_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("cs_n", 32'(adc_cs_n), 32'(!(ph >= 0 && ph <= 7)));
    chk("busy", 32'(busy), 32'(ph != -1));
    chk("valid", 32'(sample_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("data", 32'(sample_data), 32'(q[0]));
  endtask

  task automatic mstep(input logic e, input logic r, input logic c);
    logic d;
    logic pop;
    logic full;
    int   nph;
    d = 1'($urandom_range(0, 1));
    if (ph >= 0 && ph <= 7) begin
      if (ph == 0) begin
        if (txq.size() > 0) txw = txq.pop_front();
        else txw = 8'($urandom);
      end
      d = txw[3'(7 - ph)];
    end
    en = e;
    adc_serial_in = d;
    sample_ready = r;
    clr_ovf = c;
    @(posedge spiclk);
    pop  = (q.size() > 0) && r;
    full = (q.size() == D);
    if (ph == -1) nph = e ? 0 : -1;
    else if (ph < 7 + G) nph = ph + 1;
    else nph = e ? 0 : -1;
    if (pop) void'(q.pop_front());
    if (ph == 7) begin
      if (!full || pop) q.push_back(txw);
      else m_ovf = 1'b1;
    end else if (c) begin
      m_ovf = 1'b0;
    end
    if (ph == 7 && !(full && !pop) && c) m_ovf = 1'b0;
    if (nph == 0) started++;
    ph = nph;
    @(negedge spiclk);
    check_all();
  endtask

  task automatic run_convs(input int n, input int rmode, input int cmode);
    logic r;
    logic c;
    started = 0;
    for (int k = 0; k < 3000; k++) begin
      if (started >= n && ph == -1) break;
      r = (rmode == 1) ? 1'b1 : (rmode == 2) ? (ph == 7) : 1'b0;
      c = (cmode == 2) ? (ph == 7) : 1'b0;
      mstep(started < n, r, c);
    end
    chk("run_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    ph = -1;
    q.delete();
    txq.delete();
    m_ovf = 1'b0;
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    en = 1'b0;
    sample_ready = 1'b0;
    clr_ovf = 1'b0;
    @(negedge spiclk);
    rst = 1'b0;
    @(negedge spiclk);
    check_all();
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    ph       = -1;
    m_ovf    = 1'b0;
    txw      = '0;
    started  = 0;
    rst = 1'b1;
    en = 1'b0;
    adc_serial_in = 1'b0;
    sample_ready = 1'b0;
    clr_ovf = 1'b0;
    @(negedge spiclk);
    @(negedge spiclk);
    chk("init_cs_n", 32'(adc_cs_n), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_valid", 32'(sample_valid), 32'd0);
    chk("init_data", 32'(sample_data), 32'd0);
    chk("init_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge spiclk);
    check_all();

    // Back-to-back 0xA5 words with a ready consumer.
    txq = '{8'hA5, 8'hA5};
    run_convs(2, 1, 0);

    // en dropped in the third CONV cycle still delivers 0x3C.
    txq = '{8'h3C};
    for (int k = 0; k < 20 && ph != 2; k++) mstep(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && ph != -1; k++) mstep(1'b0, 1'b1, 1'b0);
    chk("drop_en_idle", 32'(busy), 32'd0);

    // Fill past capacity with no consumer, then drain in order.
    for (int k = 0; k <= D; k++)
      txq.push_back((D == 1) ? 8'(8'h11 * (k + 1)) : 8'(k + 1));
    run_convs(D + 1, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("full_valid", 32'(sample_valid), 32'd1);
    for (int k = 0; k < D; k++) begin
      chk("drain", 32'(sample_data),
          (D == 1) ? 32'(8'h11 * (k + 1)) : 32'(k + 1));
      mstep(1'b0, 1'b1, 1'b0);
    end
    chk("drained", 32'(sample_valid), 32'd0);

    // Clear, refill, push+pop when full, overflow racing clear.
    mstep(1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    run_convs(D, 0, 0);
    run_convs(1, 2, 0);
    chk("no_drop_ovf", 32'(overflow), 32'd0);
    run_convs(1, 0, 2);
    chk("ovf_beats_clr", 32'(overflow), 32'd1);
    mstep(1'b0, 1'b0, 1'b1);
    chk("ovf_clr2", 32'(overflow), 32'd0);
    for (int k = 0; k < 40 && q.size() > 0; k++) mstep(1'b0, 1'b1, 1'b0);

    // Reset in the fifth CONV cycle, then a clean 0xA5.
    txq = '{8'hA5};
    for (int k = 0; k < 20 && ph != 4; k++) mstep(1'b1, 1'b1, 1'b0);
    do_reset();
    txq = '{8'hA5};
    run_convs(1, 1, 0);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      mstep(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));
    for (int k = 0; k < 60 && ph != -1; k++) mstep(1'b0, 1'b1, 1'b0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
